// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP control sequencer.
//   ctrl_word_t : 12-bit control word {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n}
//   tstate_t    : one-hot T-state ring encoding (all-zero = HALT)
package sap_pkg;

    localparam int unsigned CTRL_W   = 12;
    localparam int unsigned TSTATE_W = 6;
    localparam int unsigned OP_W     = 4;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_n;
        logic ce_n;
        logic li_n;
        logic ei_n;
        logic la_n;
        logic ea;
        logic su;
        logic eu;
        logic lb_n;
        logic lo_n;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = ctrl_word_t'(12'h3E3);

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [TSTATE_W-1:0] {
        T_NONE = 6'b000000,
        T1     = 6'b000001,
        T2     = 6'b000010,
        T3     = 6'b000100,
        T4     = 6'b001000,
        T5     = 6'b010000,
        T6     = 6'b100000
    } tstate_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer bus: run/opcode in, control word and status out.
//   run        : 1 = advance T-state, 0 = pause
//   ir_op      : opcode nibble IR[7:4]
//   ctrl       : registered control word
//   tstate     : one-hot T-state, zero in HALT
//   halted     : high while halted
//   instr_done : high during T6 of each instruction
interface control_sequencer_if;
    import sap_pkg::*;

    logic                  run;
    logic [OP_W-1:0]       ir_op;
    ctrl_word_t            ctrl;
    logic [TSTATE_W-1:0]   tstate;
    logic                  halted;
    logic                  instr_done;

    modport master (
        output run, ir_op,
        input  ctrl, tstate, halted, instr_done
    );

    modport slave (
        input  run, ir_op,
        output ctrl, tstate, halted, instr_done
    );

endinterface

// File: rtl/ring_counter.sv
// Six-state one-hot T-state ring with hold, halt-clear and self-correction.
//   clk          : clock, state changes on falling edge
//   rst          : synchronous active-low reset to T1
//   hold         : keep current state
//   halt         : force (and keep) the all-zero HALT state
//   state        : registered one-hot state
//   state_next_c : combinational next state (used by the decoder)
module ring_counter
    import sap_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                halt,
    output logic [TSTATE_W-1:0] state,
    output logic [TSTATE_W-1:0] state_next_c
);

    // Halt wins; a corrupted ring recovers to T1 even while held.
    always_comb begin
        state_next_c = state;
        if (halt) begin
            state_next_c = TSTATE_W'(T_NONE);
        end else if (!$onehot(state)) begin
            state_next_c = TSTATE_W'(T1);
        end else if (!hold) begin
            state_next_c = {state[TSTATE_W-2:0], state[TSTATE_W-1]};
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            state <= TSTATE_W'(T1);
        end else begin
            state <= state_next_c;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP-style control sequencer: T-state ring plus opcode decode to a control word.
//   clk : clock, all state changes on falling edge
//   rst : synchronous active-low reset
//   bus : control_sequencer_if slave (run, ir_op in; ctrl, tstate, halted, instr_done out)
module control_sequencer
    import sap_pkg::*;
#(
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.slave  bus
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PAUSE = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]          mode_q;
    logic [1:0]          mode_next_c;
    logic [OP_W-1:0]     op_q;
    logic [OP_W-1:0]     op_next_c;
    ctrl_word_t          ctrl_q;
    ctrl_word_t          ctrl_next_c;
    logic                halted_q;
    logic                done_q;
    logic                done_next_c;
    logic                step_c;
    logic                latch_c;
    logic                halt_entry_c;
    logic                ring_hold_c;
    logic                ring_halt_c;
    logic [OP_W-1:0]     op_sel_c;
    logic [TSTATE_W-1:0] tstate_q;
    logic [TSTATE_W-1:0] tstate_next_c;

    // Control word for a given T-state and opcode.
    function automatic ctrl_word_t decode(input logic [TSTATE_W-1:0] t,
                                          input logic [OP_W-1:0]     op);
        logic [CTRL_W-1:0] w;
        w = CTRL_W'(CTRL_IDLE);
        case (t)
            T1: w = 12'h5E3;
            T2: w = 12'hBE3;
            T3: w = 12'h263;
            T4: begin
                if (op == OP_LDA || op == OP_ADD || op == OP_SUB) begin
                    w = 12'h1A3;
                end else if (op == OP_OUT) begin
                    w = 12'h3F2;
                end
            end
            T5: begin
                if (op == OP_LDA) begin
                    w = 12'h2C3;
                end else if (op == OP_ADD || op == OP_SUB) begin
                    w = 12'h2E1;
                end
            end
            T6: begin
                if (op == OP_ADD) begin
                    w = 12'h3C7;
                end else if (op == OP_SUB) begin
                    w = 12'h3CF;
                end
            end
            default: w = CTRL_W'(CTRL_IDLE);
        endcase
        return ctrl_word_t'(w);
    endfunction

    ring_counter u_ring (
        .clk          (clk),
        .rst          (rst),
        .hold         (ring_hold_c),
        .halt         (ring_halt_c),
        .state        (tstate_q),
        .state_next_c (tstate_next_c)
    );

    // Mode register and registered outputs.
    always_ff @(negedge clk) begin
        if (!rst) begin
            mode_q   <= ST_RUN;
            op_q     <= OP_LDA;
            ctrl_q   <= ctrl_word_t'(12'h5E3);
            halted_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mode_q   <= mode_next_c;
            op_q     <= op_next_c;
            ctrl_q   <= ctrl_next_c;
            halted_q <= (mode_next_c == ST_HALT);
            done_q   <= done_next_c;
        end
    end

    // Next mode, ring controls and next-cycle outputs. Leaving PAUSE holds the
    // ring for one more edge so the paused state's word is emitted exactly once.
    always_comb begin
        mode_next_c  = mode_q;
        step_c       = 1'b0;
        latch_c      = 1'b0;
        halt_entry_c = 1'b0;
        ring_hold_c  = 1'b1;
        ring_halt_c  = 1'b0;
        op_sel_c     = op_q;
        op_next_c    = op_q;
        ctrl_next_c  = CTRL_IDLE;
        done_next_c  = 1'b0;

        case (mode_q)
            ST_HALT: begin
                mode_next_c = ST_HALT;
            end
            ST_PAUSE: begin
                mode_next_c = bus.run ? ST_RUN : ST_PAUSE;
            end
            default: begin
                step_c       = bus.run;
                latch_c      = step_c && (tstate_q == T3);
                halt_entry_c = latch_c && (bus.ir_op == HALT_OP);
                if (halt_entry_c) begin
                    mode_next_c = ST_HALT;
                end else if (!bus.run) begin
                    mode_next_c = ST_PAUSE;
                end else begin
                    mode_next_c = ST_RUN;
                end
            end
        endcase

        ring_hold_c = !step_c;
        ring_halt_c = (mode_q == ST_HALT) || halt_entry_c;

        if (latch_c) begin
            op_sel_c  = bus.ir_op;
            op_next_c = bus.ir_op;
        end

        if (!ring_halt_c && bus.run) begin
            ctrl_next_c = decode(tstate_next_c, op_sel_c);
            done_next_c = (tstate_next_c == T6);
        end
    end

    assign bus.ctrl       = ctrl_q;
    assign bus.tstate     = tstate_q;
    assign bus.halted     = halted_q;
    assign bus.instr_done = done_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed steps push expected outputs,
// a monitor pops one entry per rising edge and compares it with the DUT.
module tb_control_sequencer;
    import sap_pkg::*;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;
    localparam logic [5:0] SH = 6'b000000;

    typedef struct {
        int         id;
        logic [11:0] ctrl;
        logic [5:0]  t;
        logic        h;
        logic        d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    exp_t e;
    int   checks  = 0;
    int   passes  = 0;
    int   step_id = 0;

    control_sequencer_if bus ();

    control_sequencer #(.HALT_OP(OP_HLT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive inputs for the next falling edge and queue the outputs it should produce.
    task automatic step(input logic r, input logic rn, input logic [3:0] op,
                        input logic [11:0] c, input logic [5:0] t,
                        input logic h, input logic d);
        exp_t x;
        @(posedge clk);
        #1;
        rst        = r;
        bus.run    = rn;
        bus.ir_op  = op;
        x.id   = step_id;
        x.ctrl = c;
        x.t    = t;
        x.h    = h;
        x.d    = d;
        q.push_back(x);
        step_id++;
    endtask

    // Monitor: outputs settle on the falling edge, compared on the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (12'(bus.ctrl) == e.ctrl && bus.tstate == e.t &&
                    bus.halted == e.h && bus.instr_done == e.d) begin
                    passes++;
                end else begin
                    $display("FAIL step %0d: got ctrl=%h tstate=%b halted=%b done=%b, want ctrl=%h tstate=%b halted=%b done=%b",
                             e.id, 12'(bus.ctrl), bus.tstate, bus.halted, bus.instr_done,
                             e.ctrl, e.t, e.h, e.d);
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        bus.run   = 1'b0;
        bus.ir_op = 4'h0;

        // reset values, reset beats run
        step(0, 0, 4'h0, 12'h5E3, S1, 0, 0);
        step(0, 1, 4'h0, 12'h5E3, S1, 0, 0);

        // LDA
        step(1, 1, 4'h0, 12'hBE3, S2, 0, 0);
        step(1, 1, 4'h0, 12'h263, S3, 0, 0);
        step(1, 1, 4'h0, 12'h1A3, S4, 0, 0);
        step(1, 1, 4'h0, 12'h2C3, S5, 0, 0);
        step(1, 1, 4'h0, 12'h3E3, S6, 0, 1);
        step(1, 1, 4'h0, 12'h5E3, S1, 0, 0);

        // SUB, ir_op changed to OUT after the latch must not matter
        step(1, 1, 4'h2, 12'hBE3, S2, 0, 0);
        step(1, 1, 4'h2, 12'h263, S3, 0, 0);
        step(1, 1, 4'h2, 12'h1A3, S4, 0, 0);
        step(1, 1, 4'hE, 12'h2E1, S5, 0, 0);
        step(1, 1, 4'hE, 12'h3CF, S6, 0, 1);
        step(1, 1, 4'hE, 12'h5E3, S1, 0, 0);

        // ADD
        step(1, 1, 4'h1, 12'hBE3, S2, 0, 0);
        step(1, 1, 4'h1, 12'h263, S3, 0, 0);
        step(1, 1, 4'h1, 12'h1A3, S4, 0, 0);
        step(1, 1, 4'h1, 12'h2E1, S5, 0, 0);
        step(1, 1, 4'h1, 12'h3C7, S6, 0, 1);
        step(1, 1, 4'h1, 12'h5E3, S1, 0, 0);

        // OUT with a one-cycle pause in T6
        step(1, 1, 4'hE, 12'hBE3, S2, 0, 0);
        step(1, 1, 4'hE, 12'h263, S3, 0, 0);
        step(1, 1, 4'hE, 12'h3F2, S4, 0, 0);
        step(1, 1, 4'hE, 12'h3E3, S5, 0, 0);
        step(1, 1, 4'hE, 12'h3E3, S6, 0, 1);
        step(1, 0, 4'hE, 12'h3E3, S6, 0, 0);
        step(1, 1, 4'hE, 12'h3E3, S6, 0, 1);
        step(1, 1, 4'hE, 12'h5E3, S1, 0, 0);

        // NOP (4'h7) with a three-cycle pause in T2: one BE3 after resume
        step(1, 1, 4'h7, 12'hBE3, S2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 4'h7, 12'h3E3, S2, 0, 0);
        end
        step(1, 1, 4'h7, 12'hBE3, S2, 0, 0);
        step(1, 1, 4'h7, 12'h263, S3, 0, 0);
        step(1, 1, 4'h7, 12'h3E3, S4, 0, 0);
        step(1, 1, 4'h7, 12'h3E3, S5, 0, 0);
        step(1, 1, 4'h7, 12'h3E3, S6, 0, 1);
        step(1, 1, 4'h7, 12'h5E3, S1, 0, 0);

        // reset during T5 of ADD: no T6 word
        step(1, 1, 4'h1, 12'hBE3, S2, 0, 0);
        step(1, 1, 4'h1, 12'h263, S3, 0, 0);
        step(1, 1, 4'h1, 12'h1A3, S4, 0, 0);
        step(1, 1, 4'h1, 12'h2E1, S5, 0, 0);
        step(0, 1, 4'h1, 12'h5E3, S1, 0, 0);
        step(1, 1, 4'h1, 12'hBE3, S2, 0, 0);

        // HALT, entered after a pause in T3
        step(1, 1, 4'hF, 12'h263, S3, 0, 0);
        step(1, 0, 4'hF, 12'h3E3, S3, 0, 0);
        step(1, 1, 4'hF, 12'h263, S3, 0, 0);
        step(1, 1, 4'hF, 12'h3E3, SH, 1, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 1'(i % 2), 4'(i), 12'h3E3, SH, 1, 0);
        end
        step(0, 1, 4'h0, 12'h5E3, S1, 0, 0);
        step(1, 1, 4'h0, 12'hBE3, S2, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
